// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port of alu_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface alu_arbiter_if #(
    parameter int N = 4
) ();
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [1:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [1:0]   req1_op;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;

    logic         busy;
    logic [7:0]   op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        output busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_last_grant;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [1:0]   r_op;
    logic         r_id;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_result;
    logic [3:0]   r_rsp_flags;
    logic [7:0]   r_op_count;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;

    // rst_n gates the grants so both readys read low while reset is held.
    assign w_idle   = rst_n && (r_state == IDLE);
    assign w_grant0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 2'b00;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
            r_op_count   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0) begin
                        r_a          <= bus.req0_a;
                        r_b          <= bus.req0_b;
                        r_op         <= bus.req0_op;
                        r_id         <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_state      <= EXEC;
                    end else if (w_grant1) begin
                        r_a          <= bus.req1_a;
                        r_b          <= bus.req1_b;
                        r_op         <= bus.req1_op;
                        r_id         <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_flags  <= bus.alu_flags;
                    r_rsp_id     <= r_id;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (r_op_count != 8'hFF) begin
                            r_op_count <= r_op_count + 8'd1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.busy       = (r_state != IDLE);
    assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations plus sequences
// for contention, back-pressure, reset mid-operation and counter saturation.
module tb_alu_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU: flags {N,Z,C,V}; SUB carry is the carry out of a + ~b + 1.
    logic [N:0]   alu_sum;
    logic [N-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_op)
            2'b00: begin
                alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                alu_res = alu_sum[N-1:0];
                alu_c   = alu_sum[N];
                alu_v   = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (alu_res[N-1] != bus.alu_a[N-1]);
            end
            2'b01: begin
                alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + (N+1)'(1);
                alu_res = alu_sum[N-1:0];
                alu_c   = alu_sum[N];
                alu_v   = (bus.alu_a[N-1] != bus.alu_b[N-1]) && (alu_res[N-1] != bus.alu_a[N-1]);
            end
            2'b10: alu_res = bus.alu_a & bus.alu_b;
            default: alu_res = bus.alu_a | bus.alu_b;
        endcase
        bus.alu_result = alu_res;
        bus.alu_flags  = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
    end

    typedef struct {
        logic       v0;
        logic [1:0] op0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       v1;
        logic [1:0] op1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       exp_id;
        logic [3:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[8];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got = 1'b0;
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
        bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
        for (int c = 0; c < 8 && !got; c++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d grant_seen", idx), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("v%0d grant_id", idx), 32'(bus.req1_ready), 32'(v.exp_id));
            chk($sformatf("v%0d one_ready", idx), 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            @(negedge clk);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            #1;
            chk($sformatf("v%0d exec_rsp_valid", idx), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("v%0d exec_alu_a", idx), 32'(bus.alu_a), 32'(v.exp_id ? v.a1 : v.a0));
            @(negedge clk);
            #1;
            chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("v%0d rsp_id", idx), 32'(bus.rsp_id), 32'(v.exp_id));
            chk($sformatf("v%0d rsp_result", idx), 32'(bus.rsp_result), 32'(v.exp_res));
            chk($sformatf("v%0d rsp_flags", idx), 32'(bus.rsp_flags), 32'(v.exp_flags));
            @(negedge clk);
            #1;
            chk($sformatf("v%0d rsp_done", idx), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("v%0d busy_idle", idx), 32'(bus.busy), 32'd0);
            chk($sformatf("v%0d op_count", idx), 32'(bus.op_count), 32'(idx + 1));
        end
        $display("vec %0d: id=%0d result=%b flags=%b op_count=%0d", idx, bus.rsp_id,
                 bus.rsp_result, bus.rsp_flags, bus.op_count);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Both requesters valid until n grants are seen; grants must alternate starting at first_id
    // and responses must come back in grant order.
    task automatic run_ops(input int n, input logic first_id, input string tag);
        int   grants = 0;
        int   done   = 0;
        int   cyc    = 0;
        logic exp_g  = first_id;
        logic q[$];
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 4'd4; bus.req1_b = 4'd1;
        while (done < n && cyc < n * 4 + 20) begin
            if (grants == n) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                chk({tag, " one_ready"}, 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                chk({tag, " grant_order"}, 32'(bus.req1_ready), 32'(exp_g));
                q.push_back(bus.req1_ready);
                exp_g = ~exp_g;
                grants++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() > 0) chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(q.pop_front()));
                else chk({tag, " rsp_without_grant"}, 32'(q.size()), 32'd1);
                done++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ops_done"}, 32'(done), 32'(n));
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        $display("%s: %0d grants, %0d responses, op_count=%0d", tag, grants, done, bus.op_count);
    endtask

    initial begin
        //          v0  op0    a0     b0     v1  op1    a1     b1     id  res      flags
        vecs[0] = '{1, 2'b00, 4'd7,  4'd9,  0, 2'b00, 4'd0,  4'd0,  0, 4'b0000, 4'b0110};
        vecs[1] = '{0, 2'b00, 4'd0,  4'd0,  1, 2'b01, 4'd3,  4'd5,  1, 4'b1110, 4'b1000};
        vecs[2] = '{1, 2'b10, 4'hC,  4'hA,  1, 2'b11, 4'hC,  4'hA,  0, 4'b1000, 4'b1000};
        vecs[3] = '{1, 2'b00, 4'd1,  4'd1,  1, 2'b11, 4'hC,  4'hA,  1, 4'b1110, 4'b1000};
        vecs[4] = '{1, 2'b00, 4'd7,  4'd1,  0, 2'b00, 4'd0,  4'd0,  0, 4'b1000, 4'b1001};
        vecs[5] = '{0, 2'b00, 4'd0,  4'd0,  1, 2'b01, 4'd0,  4'd1,  1, 4'b1111, 4'b1000};
        vecs[6] = '{1, 2'b01, 4'd5,  4'd5,  0, 2'b00, 4'd0,  4'd0,  0, 4'b0000, 4'b0110};
        vecs[7] = '{0, 2'b00, 4'd0,  4'd0,  1, 2'b00, 4'd8,  4'd8,  1, 4'b0000, 4'b0111};

        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset op_count", 32'(bus.op_count), 32'd0);
        chk("reset rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("reset rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset alu_a", 32'(bus.alu_a), 32'd0);
        $display("reset: busy=%0d rsp_valid=%0d op_count=%0d", bus.busy, bus.rsp_valid, bus.op_count);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        run_ops(4, 1'b0, "alternate4");
        chk("alternate4 op_count", 32'(bus.op_count), 32'd12);

        // Back-pressure: response must hold while rsp_ready is low, with req0 pending.
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_a = 4'd3; bus.req1_b = 4'd5;
        #1;
        chk("hold grant1", 32'(bus.req1_ready), 32'd1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("hold%0d rsp_result", i), 32'(bus.rsp_result), 32'b1110);
            chk($sformatf("hold%0d flags_nz", i), 32'(bus.rsp_flags[3:2]), 32'b10);
            chk($sformatf("hold%0d rsp_id", i), 32'(bus.rsp_id), 32'd1);
            chk($sformatf("hold%0d busy", i), 32'(bus.busy), 32'd1);
            chk($sformatf("hold%0d readys", i), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            $display("hold %0d: rsp_valid=%0d result=%b flags=%b", i, bus.rsp_valid,
                     bus.rsp_result, bus.rsp_flags);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        #1;
        chk("hold release valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("hold done rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold done op_count", 32'(bus.op_count), 32'd13);

        // Reset asserted while the operation is in EXEC.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 4'd7; bus.req0_b = 4'd9;
        #1;
        chk("rstexec grant0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("rstexec busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstexec busy0", 32'(bus.busy), 32'd0);
        chk("rstexec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstexec op_count", 32'(bus.op_count), 32'd0);
        chk("rstexec alu_a", 32'(bus.alu_a), 32'd0);
        chk("rstexec alu_b", 32'(bus.alu_b), 32'd0);
        chk("rstexec rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rstexec rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rstexec ready0", 32'(bus.req0_ready), 32'd0);
        $display("reset in EXEC: busy=%0d rsp_valid=%0d op_count=%0d", bus.busy, bus.rsp_valid,
                 bus.op_count);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rstexec after%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end

        run_ops(254, 1'b0, "sat254");
        chk("sat op_count254", 32'(bus.op_count), 32'd254);
        run_ops(1, 1'b0, "sat255");
        chk("sat op_count255", 32'(bus.op_count), 32'd255);
        run_ops(5, 1'b1, "sat260");
        chk("sat op_count260", 32'(bus.op_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4: operand/result width in bits, N >= 2.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same widths and meaning as REQ-004..007, requester 1.
REQ-009 alu_a, alu_b  output  N each  operands to the shared combinational ALU.
REQ-010 alu_op  output  2  operation code to the ALU.
REQ-011 alu_result  input  N  ALU result.
REQ-012 alu_flags  input  4  ALU flags, packed {N,Z,C,V}.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_id  output  1  requester that issued the responded operation.
REQ-016 rsp_result  output  N  registered ALU result.
REQ-017 rsp_flags  output  4  registered ALU flags {N,Z,C,V}.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 op_count  output  8  completed operations, saturating.

Function
REQ-020 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-021 IDLE: if no reqX_valid, stay IDLE; all reqX_ready low.
REQ-022 IDLE with one valid: that requester granted; its reqX_ready high combinationally that cycle.
REQ-023 IDLE with both valid: grant the requester not granted last (round-robin); last_grant resets to 1, so requester 0 wins first contention.
REQ-024 Acceptance (valid & ready) captures a, b, op and grant id into internal registers, updates last_grant, moves to EXEC.
REQ-025 reqX_ready is never high outside IDLE and never high for both requesters in the same cycle.
REQ-026 alu_a, alu_b, alu_op always driven from the internal operand registers (stable in EXEC; hold last values in IDLE/RESP).
REQ-027 EXEC lasts exactly one cycle; at its end alu_result and alu_flags are captured into rsp_result and rsp_flags, rsp_id set, state moves to RESP.
REQ-028 RESP: rsp_valid high; rsp_id, rsp_result, rsp_flags held stable until rsp_ready sampled high.
REQ-029 rsp_valid & rsp_ready: op_count increments (holds at 255), state returns to IDLE next cycle; no new acceptance in the same cycle.
REQ-030 Latency: acceptance in cycle T -> rsp_valid first high in cycle T+2; minimum issue interval 3 cycles.
REQ-031 rsp_ready already high when rsp_valid rises: handshake completes that cycle (rsp_valid high one cycle only).
REQ-032 Requester dropping valid while not granted: no transfer, no state change.
REQ-033 All state, operand, response and counter elements are registers; only reqX_ready, busy and rsp_valid are decoded from state.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, last_grant 1, operand registers 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0000, op_count 0, busy 0, reqX_ready 0.
REQ-035 Reset during EXEC or RESP discards the in-flight operation; no response is produced for it and op_count does not increment.

Verification (N=4, bench connects the team ALU combinationally)
REQ-036 Only req0 valid, ADD a=7 b=9, rsp_ready=1 -> req0_ready in cycle T, rsp_valid at T+2, rsp_id 0, rsp_result 0000, rsp_flags 0110, op_count 1.
REQ-037 Both valid from reset, req0 AND 1100&1010, req1 OR 1100|1010 -> req0 served first (result 1000, flags 1000), then req1 (result 1110, flags 1000, rsp_id 1).
REQ-038 Both valid continuously for 4 operations -> grants alternate 0,1,0,1; never two readys in one cycle.
REQ-039 req1 SUB a=3 b=5, rsp_ready low 5 cycles -> rsp_result 1110, flags N=1 Z=0 held stable 5 cycles, busy high, reqX_ready low throughout.
REQ-040 rst_n pulled low during EXEC -> all outputs at reset values immediately; no rsp_valid afterwards for that operation; op_count 0.
REQ-041 260 completed operations -> op_count reads 255 and stays 255.
